fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the immediate generator and decoder. Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Captures returned words in a one-entry instruction register (IR). Presents instr, instr_pc and the 25-bit immediate field instr[31:7] to the decode stage, with a stall input from decode and a redirect input for branches and jumps.

Parameters:
WIDTH, 32, data/address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
PC_INC, 4, sequential PC increment in bytes.
NOP_INSTR, 32'h0000_0013, IR contents when empty or at reset (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  request valid to instruction memory.
imem_addr  output  WIDTH  request address; equals fetch_pc.
imem_gnt  input  1  request accepted this cycle.
imem_rvalid  input  1  response data valid; at least 1 cycle after gnt.
imem_rdata  input  WIDTH  response instruction word.
redirect  input  1  branch/jump taken; load redirect_pc.
redirect_pc  input  WIDTH  redirect target.
stall  input  1  decode cannot accept IR this cycle.
instr_valid  output  1  IR holds a valid instruction.
instr  output  WIDTH  IR contents.
instr_pc  output  WIDTH  address of instr.
imm_field  output  WIDTH-7  instr[WIDTH-1:7]; feeds the immediate generator.

Behaviour:
- Reset (async, any state): state=BOOT, fetch_pc=RESET_PC, imem_req=0, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC.
- States: BOOT, REQ, WAIT, DRAIN.
- BOOT: imem_req=0. Goes to REQ on the first clock after reset release.
- REQ: imem_req=1 unless (instr_valid && stall); in that case imem_req=0 and the FSM stays in REQ. On imem_req && imem_gnt: go to WAIT; fetch_pc is held.
- WAIT: imem_req=0. On rvalid: IR<=rdata, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+PC_INC (mod 2^WIDTH, wraps), go to REQ.
- Consumption: IR is consumed on any cycle with instr_valid && !stall. If no load happens that cycle, instr_valid<=0 and instr<=NOP_INSTR.
- A request is granted only when the IR is empty or being consumed, so the IR never overflows.
- Peak throughput: one instruction per 2 cycles.
- Redirect has highest priority, including over stall:
  - fetch_pc<=redirect_pc with bits[1:0] forced to 0; instr_valid<=0; IR<=NOP_INSTR.
  - In REQ with no gnt that cycle, or in BOOT: next state is REQ.
  - If a request is outstanding (WAIT without rvalid, or REQ with gnt the same cycle): go to DRAIN.
  - WAIT with rvalid the same cycle: data is discarded, go to REQ.
- DRAIN: imem_req=0. On rvalid, discard data and go to REQ. A further redirect while in DRAIN updates fetch_pc and the FSM stays in DRAIN.
- imm_field is combinational from the IR; zero added latency.
- rvalid outside WAIT/DRAIN is ignored.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt (WIDTH) and perf_stall_cnt (WIDTH).
  - perf_fetch_cnt increments on each IR load.
  - perf_stall_cnt increments on each cycle with instr_valid && stall.
  - Both reset to 0 and wrap at 2^WIDTH.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, no stall -> imem_addr sequence 0,4,8; instr_valid pulses with instr_pc 0,4,8; imm_field = rdata[31:7].
- IR valid with stall=1 for 5 cycles -> imem_req=0, instr/instr_pc held stable; perf_stall_cnt +5 if FETCH_PERF_EN.
- Redirect to 0x103 while in WAIT, rvalid 3 cycles later -> response discarded, instr_valid stays 0, next imem_addr=0x100.
- Redirect on the same cycle as rvalid -> rdata dropped, next request to redirect target, instr_valid=0.
- Reset asserted mid-WAIT -> outputs return to reset values the same cycle; first request to RESET_PC two cycles after release.
- fetch_pc=32'hFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding a one-entry IR.
// Optional macro FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      PC_INC    = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-8:0] imm_field
`ifdef FETCH_PERF_EN
  ,
  output logic [WIDTH-1:0] perf_fetch_cnt,
  output logic [WIDTH-1:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StDrain} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_ipc;
  logic             r_valid;

  logic             w_req;
  logic             w_accept;
  logic             w_load;
  logic             w_consume;
  logic [WIDTH-1:0] w_redir_pc;

  // Holding off the request while a stalled IR is full keeps the IR from overflowing.
  assign w_req      = (r_state == StReq) && !(r_valid && stall);
  assign w_accept   = w_req && imem_gnt;
  assign w_load     = (r_state == StWait) && imem_rvalid && !redirect;
  assign w_consume  = r_valid && !stall;
  assign w_redir_pc = redirect_pc & ~WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INSTR;
      r_ipc   <= RESET_PC;
      r_valid <= 1'b0;
    end else if (redirect) begin
      r_pc    <= w_redir_pc;
      r_valid <= 1'b0;
      r_ir    <= NOP_INSTR;
      // An in-flight response must be drained before fetching from the new target.
      case (r_state)
        StReq:           r_state <= w_accept ? StDrain : StReq;
        StWait, StDrain: r_state <= imem_rvalid ? StReq : StDrain;
        default:         r_state <= StReq;
      endcase
    end else begin
      case (r_state)
        StBoot:  r_state <= StReq;
        StReq:   if (w_accept) r_state <= StWait;
        StWait:  if (imem_rvalid) r_state <= StReq;
        StDrain: if (imem_rvalid) r_state <= StReq;
        default: r_state <= StBoot;
      endcase
      if (w_load) begin
        r_ir    <= imem_rdata;
        r_ipc   <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= r_pc + WIDTH'(PC_INC);
      end else if (w_consume) begin
        r_valid <= 1'b0;
        r_ir    <= NOP_INSTR;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_ir;
  assign instr_pc    = r_ipc;
  assign imm_field   = r_ir[WIDTH-1:7];

`ifdef FETCH_PERF_EN
  logic [WIDTH-1:0] r_perf_fetch;
  logic [WIDTH-1:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_load) r_perf_fetch <= r_perf_fetch + WIDTH'(1);
      if (r_valid && stall) r_perf_stall <= r_perf_stall + WIDTH'(1);
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan scenarios with literal checks, then random traffic,
// all checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [24:0] imm_field;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .imm_field   (imm_field)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Stimulus knobs applied by tick()
  logic        t_rst = 1'b1, t_stall = 1'b0, t_redirect = 1'b0, t_gnt = 1'b1, t_spur = 1'b0;
  logic [31:0] t_rpc = '0, t_rdata = '0;
  int          t_lat = 0;

  // Transaction-level model: booted flag, one in-flight request (maybe to be dropped), IR.
  logic        m_booted, m_out, m_drop, m_valid;
  int          m_lat;
  logic [31:0] m_pc, m_ipc, m_ir, m_fetch_cnt, m_stall_cnt;

  task automatic model_reset();
    m_booted = 0; m_out = 0; m_drop = 0; m_valid = 0; m_lat = 0;
    m_pc = '0; m_ipc = '0; m_ir = NOP; m_fetch_cnt = '0; m_stall_cnt = '0;
  endtask

  function automatic logic exp_req();
    return m_booted && !m_out && !(m_valid && stall);
  endfunction

  task automatic model_step();
    logic acc, resp, cons, was_out;
    if (rst) begin
      model_reset();
      return;
    end
    acc     = exp_req() && imem_gnt;
    was_out = m_out;
    resp    = m_out && imem_rvalid;
    cons    = m_valid && !stall;
    if (m_valid && stall) m_stall_cnt++;
    if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; m_valid = 0; m_ir = NOP; m_booted = 1;
      if (resp) begin m_out = 0; m_drop = 0; end
      else if (acc) begin m_out = 1; m_drop = 1; m_lat = t_lat; end
      else if (m_out) m_drop = 1;
    end else if (!m_booted) begin
      m_booted = 1;
    end else begin
      if (resp) begin
        m_out = 0;
        if (!m_drop) begin
          m_ir = imem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4; m_fetch_cnt++;
        end else if (cons) begin
          m_valid = 0; m_ir = NOP;
        end
        m_drop = 0;
      end else begin
        if (acc) begin m_out = 1; m_drop = 0; m_lat = t_lat; end
        if (cons) begin m_valid = 0; m_ir = NOP; end
      end
    end
    if (was_out && !resp && m_lat > 0) m_lat--;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check("instr", instr, m_ir);
    check("instr_pc", instr_pc, m_ipc);
    check("imm_field", {7'b0, imm_field}, {7'b0, m_ir[31:7]});
`ifdef FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
    check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
  endtask

  // One clock cycle: drive inputs after negedge, compare, advance the model before posedge.
  task automatic tick();
    @(negedge clk);
    rst = t_rst;
    if (rst) model_reset();
    stall       = t_stall;
    redirect    = t_redirect;
    redirect_pc = t_rpc;
    imem_gnt    = t_gnt;
    imem_rdata  = t_rdata;
    imem_rvalid = m_out ? (m_lat == 0) : t_spur;
    #1;
    compare_all();
    model_step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Sequential fetch, gnt tied high, rvalid one cycle after gnt
    t_rst = 0; tick();
    check("boot_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("req0", {31'b0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h0);
    t_rdata = 32'h1234_5678; tick();
    check("wait_valid", {31'b0, instr_valid}, 32'd0);
    t_rdata = 32'hDEAD_BEEF; tick();
    check("v0", {31'b0, instr_valid}, 32'd1);
    check("instr0", instr, 32'h1234_5678);
    check("ipc0", instr_pc, 32'h0);
    check("imm0", {7'b0, imm_field}, 32'h0024_68AC);
    check("addr4", imem_addr, 32'h4);
    tick();
    t_rdata = 32'hCAFE_F00D; tick();
    check("ipc4", instr_pc, 32'h4);
    check("addr8", imem_addr, 32'h8);
    tick();

    // Stall with a full IR for 5 cycles
    t_stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", instr, 32'hCAFE_F00D);
      check("stall_ipc", instr_pc, 32'h8);
    end
    t_stall = 0; t_lat = 3; tick();
    check("addr12", imem_addr, 32'hC);
`ifdef FETCH_PERF_EN
    check("perf_stall5", perf_stall_cnt, 32'd5);
    check("perf_fetch3", perf_fetch_cnt, 32'd3);
`endif

    // Redirect while WAIT, response 3 cycles later is dropped
    t_redirect = 1; t_rpc = 32'h103; tick();
    t_redirect = 0; tick();
    check("drain_req", {31'b0, imem_req}, 32'd0);
    check("drain_addr", imem_addr, 32'h100);
    tick();
    t_rdata = 32'hBAD0_BAD0; tick();
    t_lat = 0; tick();
    check("redir_valid", {31'b0, instr_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h100);

    // Redirect on the same cycle as rvalid, target near the top of memory
    t_redirect = 1; t_rpc = 32'hFFFF_FFFE; t_rdata = 32'h0BAD_0BAD; tick();
    t_redirect = 0; tick();
    check("same_valid", {31'b0, instr_valid}, 32'd0);
    check("same_addr", imem_addr, 32'hFFFF_FFFC);
    t_rdata = 32'h0000_00B7; tick();
    tick();
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_imm", {7'b0, imm_field}, 32'h1);

    // Reset in the middle of WAIT
    @(posedge clk); #2; rst = 1; #1;
    model_reset();
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_ipc", instr_pc, 32'd0);
    compare_all();
    t_rst = 1; tick();
    t_rst = 0; tick();
    check("post_rst_req0", {31'b0, imem_req}, 32'd0);
    tick();
    check("post_rst_req1", {31'b0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      t_rst      = ($urandom % 600) == 0;
      t_stall    = ($urandom % 100) < 30;
      t_gnt      = ($urandom % 100) < 60;
      t_redirect = ($urandom % 100) < 6;
      t_rpc      = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      t_lat      = int'($urandom % 4);
      t_spur     = ($urandom % 100) < 15;
      t_rdata    = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
